cdb_arbiter: RTL

//  Upstream feeder of the CDB output latch in the Tomasulo core. Collects completed results
//  (ROB tag, result, rs1/rs2 operand values) from NUM_SRC functional units through 1-entry

---
 rtl/cdb_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Feeds the common data bus (CDB) output latch of the Tomasulo core. Every
// functional unit hands its completed result (ROB tag, result value and the
// rs1/rs2 operand values) to a private one-entry holding buffer. One held
// result per cycle is picked round-robin and driven out as a registered
// broadcast. Reservation stations and the ROB snoop that broadcast.
//
// Pipeline:
//   p0 : per-source holding buffers (vld_p0 + payload)
//   p1 : registered CDB broadcast (vld_p1 + payload)
//
// Parameters:
//   NUM_SRC  number of functional-unit result ports (>= 2)
//   TAG_W    ROB tag width
//   DATA_W   width of result and operand values
//
// Ports:
//   clk           clock, every state update on the rising edge
//   rst           synchronous active-high reset, overrides everything
//   flush         synchronous mispredict flush, drops every pending result
//   src_valid     per-source result valid
//   src_ready     per-source accept; a transfer happens on valid & ready
//   src_tag       per-source ROB tag, slice i = [i*TAG_W +: TAG_W]
//   src_data      per-source result value, slice i = [i*DATA_W +: DATA_W]
//   src_rs1_data  per-source rs1 operand value
//   src_rs2_data  per-source rs2 operand value
//   cdb_valid     registered broadcast valid
//   cdb_en        CDB latch enable, identical to cdb_valid
//   cdb_tag       registered broadcast ROB tag
//   cdb_data      registered broadcast result
//   cdb_rs1_data  registered broadcast rs1 value
//   cdb_rs2_data  registered broadcast rs2 value
// -----------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC*DATA_W-1:0] src_rs1_data,
    input  logic [NUM_SRC*DATA_W-1:0] src_rs2_data,
    output logic                      cdb_valid,
    output logic                      cdb_en,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [DATA_W-1:0]         cdb_rs1_data,
    output logic [DATA_W-1:0]         cdb_rs2_data
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Holding buffers
    logic [NUM_SRC-1:0] vld_p0;
    logic [TAG_W-1:0]   tag_p0 [NUM_SRC];
    logic [DATA_W-1:0]  data_p0 [NUM_SRC];
    logic [DATA_W-1:0]  rs1_p0 [NUM_SRC];
    logic [DATA_W-1:0]  rs2_p0 [NUM_SRC];

    // Arbitration state and result
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_SRC-1:0] grant;
    logic               accept_ok;

    // Broadcast registers
    logic               vld_p1;
    logic [TAG_W-1:0]   tag_p1;
    logic [DATA_W-1:0]  data_p1;
    logic [DATA_W-1:0]  rs1_p1;
    logic [DATA_W-1:0]  rs2_p1;

    // Round-robin search starting at rr_ptr; the first held entry wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_any && vld_p0[idx]) begin
                grant_any = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Pointer moves to the source after the winner, wrapping at NUM_SRC.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (grant_any) begin
            if (grant_idx == PTR_W'(NUM_SRC - 1)) begin
                rr_ptr_nxt = '0;
            end else begin
                rr_ptr_nxt = grant_idx + PTR_W'(1);
            end
        end
    end

    // Nothing is accepted while reset or flush is asserted, so a handshake
    // in a flush cycle can never leave a stale entry behind.
    assign accept_ok = !rst && !flush;

    // ---- stage p0 : per-source holding buffers ----
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign grant[g] = grant_any && (grant_idx == PTR_W'(g));

        // A source whose entry is leaving this cycle may refill it on the
        // same edge, which keeps an uncontended source at one result/cycle.
        assign src_ready[g] = accept_ok && (!vld_p0[g] || grant[g]);

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                vld_p0[g] <= 1'b0;
            end else if (src_valid[g] && src_ready[g]) begin
                vld_p0[g] <= 1'b1;
            end else if (grant[g]) begin
                vld_p0[g] <= 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (src_valid[g] && src_ready[g]) begin
                tag_p0[g]  <= src_tag[g*TAG_W +: TAG_W];
                data_p0[g] <= src_data[g*DATA_W +: DATA_W];
                rs1_p0[g]  <= src_rs1_data[g*DATA_W +: DATA_W];
                rs2_p0[g]  <= src_rs2_data[g*DATA_W +: DATA_W];
            end
        end
    end

    // ---- stage p1 : registered CDB broadcast ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            rr_ptr  <= '0;
            tag_p1  <= '0;
            data_p1 <= '0;
            rs1_p1  <= '0;
            rs2_p1  <= '0;
        end else if (flush) begin
            // Payload and pointer are kept; only the broadcast is squashed.
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= grant_any;
            rr_ptr <= rr_ptr_nxt;
            if (grant_any) begin
                tag_p1  <= tag_p0[grant_idx];
                data_p1 <= data_p0[grant_idx];
                rs1_p1  <= rs1_p0[grant_idx];
                rs2_p1  <= rs2_p0[grant_idx];
            end
        end
    end

    assign cdb_valid    = vld_p1;
    assign cdb_en       = vld_p1;
    assign cdb_tag      = tag_p1;
    assign cdb_data     = data_p1;
    assign cdb_rs1_data = rs1_p1;
    assign cdb_rs2_data = rs2_p1;

endmodule
